// File: rtl/mgt_01_div_unit_pkg.sv
// Shared definitions for the iterative divider: the operation encoding
// used by the instruction side and the datapath/FSM types used by modules.

package Instruction_pkg;

    typedef enum logic [1:0] {
        DIV_  = 2'b00,
        DIVU_ = 2'b01,
        REM_  = 2'b10,
        REMU_ = 2'b11
    } div_ops_e;

    // Signed variants need absolute values and sign correction.
    function automatic logic is_signed_op(input div_ops_e op);
        return (op == DIV_) || (op == REM_);
    endfunction

    // Quotient-producing variants; the others return the remainder.
    function automatic logic is_quot_op(input div_ops_e op);
        return (op == DIV_) || (op == DIVU_);
    endfunction

endpackage : Instruction_pkg

package Modules_pkg;

    localparam int XLEN      = 32;
    localparam int DIV_STEPS = XLEN;

    typedef logic [XLEN-1:0] data_u;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        DIVIDE,
        RESTORE,
        DONE
    } div_state_e;

endpackage : Modules_pkg

// File: rtl/mgt_01_div_unit_if.sv
// Request/response bundle of the divider: operands and operation in,
// ready/valid handshake and result out.

interface mgt_01_div_unit_if;
    import Instruction_pkg::*;
    import Modules_pkg::*;

    logic     valid_i;
    data_u    dividend_i;
    data_u    divisor_i;
    div_ops_e ops_i;
    logic     ready_o;
    logic     valid_o;
    data_u    result_o;
    logic     div_zero_o;

    // Requester side.
    modport master (
        output valid_i, dividend_i, divisor_i, ops_i,
        input  ready_o, valid_o, result_o, div_zero_o
    );

    // Divider side.
    modport slave (
        input  valid_i, dividend_i, divisor_i, ops_i,
        output ready_o, valid_o, result_o, div_zero_o
    );

endinterface : mgt_01_div_unit_if

// File: rtl/mgt_01_div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Normal requests take PREP, XLEN DIVIDE steps, RESTORE and DONE;
// divide-by-zero and signed overflow complete straight from IDLE to DONE.

module mgt_01_div_unit #(
    parameter int XLEN = Modules_pkg::XLEN
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             clk_en_i,
    input  logic             flush_i,
    mgt_01_div_unit_if.slave bus
);
    import Instruction_pkg::*;
    import Modules_pkg::div_state_e;
    import Modules_pkg::IDLE;
    import Modules_pkg::PREP;
    import Modules_pkg::DIVIDE;
    import Modules_pkg::RESTORE;
    import Modules_pkg::DONE;
    import Modules_pkg::DIV_STEPS;

    localparam logic [XLEN-1:0] MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [4:0]      LAST_STEP = 5'(DIV_STEPS - 1);

    div_state_e      state_q, state_d;
    div_ops_e        op_q, op_d;
    logic [XLEN-1:0] dividend_q, dividend_d;   // dividend, then quotient bits shift in
    logic [XLEN-1:0] divisor_q, divisor_d;
    logic [XLEN:0]   rem_q, rem_d;             // partial remainder, one guard bit
    logic [XLEN-1:0] result_q, result_d;
    logic [4:0]      cnt_q, cnt_d;
    logic            neg_quot_q, neg_quot_d;
    logic            neg_rem_q, neg_rem_d;
    logic            div_zero_q, div_zero_d;

    logic [XLEN:0]   rem_shift;
    logic [XLEN:0]   rem_diff;
    logic [XLEN-1:0] quot_fix;
    logic [XLEN-1:0] rem_fix;

    // One restoring step: shift in the next dividend bit, trial-subtract.
    assign rem_shift = (XLEN+1)'({rem_q, dividend_q[XLEN-1]});
    assign rem_diff  = rem_shift - {1'b0, divisor_q};

    // Sign-corrected quotient and remainder for the RESTORE state.
    assign quot_fix = neg_quot_q ? -dividend_q : dividend_q;
    assign rem_fix  = neg_rem_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];

    // Next-state and datapath update; flush wins, clk_en_i low holds everything.
    always_comb begin
        // NOTE: every _d defaults to its _q first so no path can infer a latch.
        state_d    = state_q;
        op_d       = op_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        rem_d      = rem_q;
        result_d   = result_q;
        cnt_d      = cnt_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;

        if (flush_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (clk_en_i) begin
            unique case (state_q)
                IDLE: begin
                    if (bus.valid_i) begin
                        op_d       = bus.ops_i;
                        dividend_d = bus.dividend_i;
                        divisor_d  = bus.divisor_i;
                        div_zero_d = 1'b0;
                        if (bus.divisor_i == '0) begin
                            div_zero_d = 1'b1;
                            result_d   = is_quot_op(bus.ops_i) ? '1 : bus.dividend_i;
                            state_d    = DONE;
                        end else if (is_signed_op(bus.ops_i) && (bus.dividend_i == MIN_NEG)
                                     && (bus.divisor_i == '1)) begin
                            result_d = is_quot_op(bus.ops_i) ? MIN_NEG : '0;
                            state_d  = DONE;
                        end else begin
                            state_d = PREP;
                        end
                    end
                end
                PREP: begin
                    neg_quot_d = is_signed_op(op_q) & (dividend_q[XLEN-1] ^ divisor_q[XLEN-1]);
                    neg_rem_d  = is_signed_op(op_q) & dividend_q[XLEN-1];
                    if (is_signed_op(op_q) && dividend_q[XLEN-1]) dividend_d = -dividend_q;
                    if (is_signed_op(op_q) && divisor_q[XLEN-1])  divisor_d  = -divisor_q;
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = DIVIDE;
                end
                DIVIDE: begin
                    if (rem_diff[XLEN]) begin
                        rem_d      = rem_shift;
                        dividend_d = {dividend_q[XLEN-2:0], 1'b0};
                    end else begin
                        rem_d      = rem_diff;
                        dividend_d = {dividend_q[XLEN-2:0], 1'b1};
                    end
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == LAST_STEP) state_d = RESTORE;
                end
                RESTORE: begin
                    result_d = is_quot_op(op_q) ? quot_fix : rem_fix;
                    cnt_d    = '0;
                    state_d  = DONE;
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n_i) begin
            state_q    <= IDLE;
            op_q       <= DIV_;
            dividend_q <= '0;
            divisor_q  <= '0;
            rem_q      <= '0;
            result_q   <= '0;
            cnt_q      <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            rem_q      <= rem_d;
            result_q   <= result_d;
            cnt_q      <= cnt_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign bus.ready_o    = (state_q == IDLE);
    assign bus.valid_o    = (state_q == DONE);
    assign bus.result_o   = result_q;
    assign bus.div_zero_o = div_zero_q;

endmodule : mgt_01_div_unit
